// File: rtl/mips_cpu_pkg.sv
// Shared types for the MIPS data-memory path: LSU opcodes, LSU states, byte-enable constants.
// LWL/LWR support is compiled in when LSU_LWLR_EN is defined.
package mips_cpu_pkg;

  typedef enum logic [3:0] {
    LB  = 4'd0,
    LBU = 4'd1,
    LH  = 4'd2,
    LHU = 4'd3,
    LW  = 4'd4,
    SB  = 4'd5,
    SH  = 4'd6,
    SW  = 4'd7,
    LWL = 4'd8,
    LWR = 4'd9
  } lsu_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } lsu_state_t;

  localparam logic [3:0] BE_NONE    = 4'b0000;
  localparam logic [3:0] BE_BYTE0   = 4'b0001;
  localparam logic [3:0] BE_LO_HALF = 4'b0011;
  localparam logic [3:0] BE_HI_HALF = 4'b1100;
  localparam logic [3:0] BE_ALL     = 4'b1111;

  function automatic logic lsu_is_load(input logic [3:0] op);
    return (op <= 4'(LW)) || (op == 4'(LWL)) || (op == 4'(LWR));
  endfunction

  // Misaligned address or an opcode this build cannot execute.
  function automatic logic lsu_op_error(input logic [3:0] op, input logic [1:0] k);
    logic err;
    err = 1'b1;
    case (op)
      LB, LBU, SB:  err = 1'b0;
      LH, LHU, SH:  err = k[0];
      LW, SW:       err = |k;
`ifdef LSU_LWLR_EN
      LWL, LWR:     err = 1'b0;
`else
      LWL, LWR:     err = 1'b1;
`endif
      default:      err = 1'b1;
    endcase
    return err;
  endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Avalon-MM data bus between the load/store unit (master) and data memory (slave).
interface load_store_unit_if;
  logic [31:0] avm_address;
  logic        avm_read;
  logic        avm_write;
  logic [31:0] avm_writedata;
  logic [3:0]  avm_byteenable;
  logic        avm_waitrequest;
  logic [31:0] avm_readdata;

  modport master (
    output avm_address, avm_read, avm_write, avm_writedata, avm_byteenable,
    input  avm_waitrequest, avm_readdata
  );

  modport slave (
    input  avm_address, avm_read, avm_write, avm_writedata, avm_byteenable,
    output avm_waitrequest, avm_readdata
  );
endinterface

// File: rtl/lsu_lane_align.sv
// Load lane alignment: moves the addressed byte/halfword to bit 0 (zero-extended),
// and with LSU_LWLR_EN defined performs the LWL/LWR merge with the old rt value.
module lsu_lane_align
  import mips_cpu_pkg::*;
(
  input  logic [3:0]  op,
  input  logic [1:0]  k,
  input  logic [31:0] rdata,
  input  logic [31:0] rt_old,
  output logic [31:0] data
);

  logic [4:0]  k_bits;
  logic [31:0] byte_shifted;

  assign k_bits       = {k, 3'b000};
  assign byte_shifted = rdata >> k_bits;

`ifdef LSU_LWLR_EN
  // LWL shifts left by 3-k bytes, which for a 2-bit k is simply ~k.
  logic [4:0]  lwl_bits;
  logic [31:0] lwl_data;
  logic [31:0] lwr_data;

  assign lwl_bits = {~k, 3'b000};
  assign lwl_data = (rdata << lwl_bits) | (rt_old & ~(32'hFFFF_FFFF << lwl_bits));
  assign lwr_data = (rdata >> k_bits) | (rt_old & ~(32'hFFFF_FFFF >> k_bits));
`else
  logic unused_rt_old;
  assign unused_rt_old = ^rt_old;
`endif

  always_comb begin
    data = rdata;
    case (op)
      LB, LBU: data = {24'h0, byte_shifted[7:0]};
      LH, LHU: data = {16'h0, (k[1] ? rdata[31:16] : rdata[15:0])};
`ifdef LSU_LWLR_EN
      LWL:     data = lwl_data;
      LWR:     data = lwr_data;
`endif
      default: data = rdata;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Data-memory stage: runs one Avalon-MM read or write per command and aligns load data.
// LWL/LWR are executed only when LSU_LWLR_EN is defined; otherwise they take the error path.
module load_store_unit
  import mips_cpu_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [3:0]        op,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  input  logic [31:0]       rt_old,
  output logic              busy,
  output logic              done,
  output logic              addr_error,
  output logic [31:0]       data_readdata,
  load_store_unit_if.master avm
);

  lsu_state_t        state_reg, state_next;
  logic [3:0]        op_reg;
  logic [ADDR_W-1:0] addr_reg;
  logic [31:0]       wdata_reg;
  logic [31:0]       rt_old_reg;
  logic              err_reg;
  logic [31:0]       data_reg;

  logic        accept;
  logic        cmd_err;
  logic        is_load;
  logic        req_exit;
  logic [31:0] aligned_data;
  logic [31:0] word_addr;
  logic [31:0] sb_lanes;
  logic [31:0] sh_lanes;

  assign cmd_err  = lsu_op_error(op, addr[1:0]);
  assign is_load  = lsu_is_load(op_reg);
  assign req_exit = (state_reg == REQ) && !avm.avm_waitrequest;

  always_comb begin
    state_next = state_reg;
    accept     = 1'b0;
    case (state_reg)
      IDLE: if (start) begin
        accept     = 1'b1;
        state_next = cmd_err ? DONE : REQ;
      end
      REQ:     if (!avm.avm_waitrequest) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg  <= IDLE;
      op_reg     <= 4'd0;
      addr_reg   <= '0;
      wdata_reg  <= 32'd0;
      rt_old_reg <= 32'd0;
      err_reg    <= 1'b0;
      data_reg   <= 32'd0;
    end else begin
      state_reg <= state_next;
      if (accept) begin
        op_reg     <= op;
        addr_reg   <= addr;
        wdata_reg  <= wdata;
        rt_old_reg <= rt_old;
        err_reg    <= cmd_err;
      end
      if (req_exit && is_load) begin
        data_reg <= aligned_data;
      end
    end
  end

  lsu_lane_align u_lane_align (
    .op     (op_reg),
    .k      (addr_reg[1:0]),
    .rdata  (avm.avm_readdata),
    .rt_old (rt_old_reg),
    .data   (aligned_data)
  );

  generate
    if (ADDR_W >= 32) begin : g_addr_full
      assign word_addr = {addr_reg[31:2], 2'b00};
    end else begin : g_addr_ext
      assign word_addr = {{(32 - ADDR_W){1'b0}}, addr_reg[ADDR_W-1:2], 2'b00};
    end
  endgenerate

  // Store data replicated across lanes; the byte enables pick the live lane(s).
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      assign sb_lanes[8*gi +: 8] = wdata_reg[7:0];
      assign sh_lanes[8*gi +: 8] = wdata_reg[8*(gi%2) +: 8];
    end
  endgenerate

  always_comb begin
    avm.avm_byteenable = BE_NONE;
    avm.avm_writedata  = 32'd0;
    if (state_reg == REQ) begin
      if (is_load) begin
        avm.avm_byteenable = BE_ALL;
      end else begin
        case (op_reg)
          SB: begin
            avm.avm_byteenable = BE_BYTE0 << addr_reg[1:0];
            avm.avm_writedata  = sb_lanes;
          end
          SH: begin
            avm.avm_byteenable = addr_reg[1] ? BE_HI_HALF : BE_LO_HALF;
            avm.avm_writedata  = sh_lanes;
          end
          default: begin
            avm.avm_byteenable = BE_ALL;
            avm.avm_writedata  = wdata_reg;
          end
        endcase
      end
    end
  end

  assign avm.avm_address = word_addr;
  assign avm.avm_read    = (state_reg == REQ) && is_load;
  assign avm.avm_write   = (state_reg == REQ) && !is_load;

  assign busy          = (state_reg != IDLE);
  assign done          = (state_reg == DONE);
  assign addr_error    = done && err_reg;
  assign data_readdata = data_reg;

endmodule
